game_status_tracker: RTL and testbench
======================================

GAME_STATUS_TRACKER -- requirements
Module: game_status_tracker

Interface
REQ-001 Parameter NUM_INVADERS, default 55: invaders per wave (1..63).
REQ-002 Parameter START_LIVES, default 3: lives loaded on start (1..7).
REQ-003 Parameter KILL_POINTS, default 10: decimal points per kill (1..99).
REQ-004 Parameter PAUSE_FRAMES, default 60: frame_tick count for hit and wave-clear pauses (1..255).
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 Port clk  in  1  system clock; all logic on its rising edge.
REQ-007 Port reset  in  1  synchronous reset, active-low.
REQ-008 Port start  in  1  one-cycle pulse from the game FSM that begins a new game.
REQ-009 Port frame_tick  in  1  one-cycle pulse per video frame.
REQ-010 Port player_hit  in  1  one-cycle pulse: player struck.
REQ-011 Port invader_killed  in  1  one-cycle pulse: one invader destroyed.
REQ-012 Port invader_landed  in  1  level: an invader reached the player row.
REQ-013 Port finished  out  1  game-over level to the game FSM.
REQ-014 Port playfield_active  out  1  high only in PLAYING; gates player and invader motion.
REQ-015 Port lives  out  3  remaining lives.
REQ-016 Port score  out  16  four BCD digits, bits 15:12 most significant.
REQ-017 Port invaders_left  out  6  invaders remaining in the current wave.
REQ-018 Port wave  out  4  wave number, 1-based, wraps 15 -> 1.

Function
REQ-019 The FSM SHALL have states IDLE, PLAYING, HIT_PAUSE, WAVE_CLEAR, DONE.
REQ-020 start in any state SHALL load lives=START_LIVES, score=0, invaders_left=NUM_INVADERS, wave=1, clear the pause counter, and enter PLAYING the next cycle.
REQ-021 player_hit, invader_killed and invader_landed SHALL be ignored outside PLAYING.
REQ-022 In PLAYING, invader_killed SHALL decrement invaders_left and add KILL_POINTS to score in BCD with digit carry, saturating at 9999, visible the next cycle.
REQ-023 In PLAYING, player_hit with lives>1 SHALL decrement lives and enter HIT_PAUSE; with lives==1 it SHALL set lives=0 and enter DONE.
REQ-024 In PLAYING, invader_landed high SHALL set lives=0 and enter DONE, overriding all other same-cycle events except score credit.
REQ-025 invader_killed reducing invaders_left to 0 SHALL enter WAVE_CLEAR unless REQ-023/REQ-024 select DONE.
REQ-026 With simultaneous kill and hit (lives>1): the kill and the life loss SHALL both be applied; next state is WAVE_CLEAR if the kill was the last, else HIT_PAUSE.
REQ-027 HIT_PAUSE SHALL count PAUSE_FRAMES frame_tick pulses, then return to PLAYING.
REQ-028 WAVE_CLEAR SHALL count PAUSE_FRAMES frame_tick pulses, then reload invaders_left=NUM_INVADERS, increment wave, and return to PLAYING.
REQ-029 finished SHALL be high exactly in DONE and stay high until start; DONE is left only by start.
REQ-030 All outputs SHALL be registered; state-change latency from an event is one cycle.

Reset
REQ-031 reset low SHALL force IDLE, finished=0, playfield_active=0, lives=0, score=0, invaders_left=0, wave=0, pause counter=0, overriding start in the same cycle.
REQ-032 Reset mid-pause or mid-game SHALL discard all progress; no event is retained.

Configuration
REQ-033 Macro EXTRA_LIFE_EN defined: when score first crosses 1000 (BCD thousands digit goes 0->1) in a game, lives SHALL increment by one, saturating at 7, once per game; undefined: no extra life, lives never increases after start.

Structure
REQ-034 A shared package SHALL hold the state enum, BCD digit typedef, and the 1000-point threshold constant.
REQ-035 One sub-module bcd_adder (4-digit BCD add with saturation, combinational) SHALL be instantiated for the score path.

Verification
REQ-036 reset low with start high -> IDLE, all outputs 0; then start -> next cycle lives=3, score=0x0000, invaders_left=55, wave=1, playfield_active=1.
REQ-037 Kill 55 invaders -> score=0x0550, WAVE_CLEAR, playfield_active=0; 60 frame_ticks -> invaders_left=55, wave=2, PLAYING.
REQ-038 Three player_hit pulses, each after its 60-tick pause -> lives 2,1, then 0 with finished=1; further kills leave score unchanged; start clears finished.
REQ-039 Same-cycle last kill and hit with lives=2 -> lives=1, invaders_left=0, WAVE_CLEAR; same-cycle invader_landed and kill -> score credited, lives=0, DONE.
REQ-040 Score preset near 9995 via kills -> saturates at 0x9999; with EXTRA_LIFE_EN, crossing 0x1000 at lives=3 -> lives=4 once, no second award at 0x2000.

Source files
------------

// File: rtl/game_status_tracker_pkg.sv
// Shared types and constants for the game status tracker: FSM states, BCD digits,
// the extra-life score threshold and a parameter-to-BCD helper.
package game_status_tracker_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAYING    = 3'd1,
    HIT_PAUSE  = 3'd2,
    WAVE_CLEAR = 3'd3,
    DONE       = 3'd4
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BONUS_THRESHOLD = 16'h1000;

  // Elaboration-time conversion of a 0..9999 integer into four packed BCD digits.
  function automatic logic [15:0] to_bcd16(input int v);
    bcd_digit_t d3, d2, d1, d0;
    d3 = 4'((v / 1000) % 10);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

endpackage

// File: rtl/game_status_tracker_bcd_adder.sv
// Four-digit BCD adder, purely combinational; any carry out of the thousands
// digit saturates the result to 9999.
module bcd_adder
  import game_status_tracker_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  bcd_digit_t digit [4];
  logic       carry;
  logic [4:0] t;

  always_comb begin
    carry = 1'b0;
    t     = '0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, carry};
      if (t > 5'd9) begin
        digit[i] = 4'(t - 5'd10);
        carry    = 1'b1;
      end else begin
        digit[i] = t[3:0];
        carry    = 1'b0;
      end
    end
    sum = carry ? 16'h9999 : {digit[3], digit[2], digit[1], digit[0]};
  end

endmodule

// File: rtl/game_status_tracker.sv
// Lives / BCD score / wave bookkeeping and play-state FSM; all outputs registered.
// Define EXTRA_LIFE_EN to award one extra life per game when the score first reaches 1000.
module game_status_tracker
  import game_status_tracker_pkg::*;
#(
  parameter int NUM_INVADERS = 55,
  parameter int START_LIVES  = 3,
  parameter int KILL_POINTS  = 10,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        player_hit,
  input  logic        invader_killed,
  input  logic        invader_landed,
  output logic        finished,
  output logic        playfield_active,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [5:0]  invaders_left,
  output logic [3:0]  wave
);

  localparam logic [15:0] KILL_BCD = to_bcd16(KILL_POINTS);

  state_t      state, state_nxt;
  logic [7:0]  pause_cnt, pause_nxt;
  logic [2:0]  lives_nxt;
  logic [3:0]  lives_sum;
  logic [15:0] score_nxt, sum;
  logic [5:0]  inv_nxt;
  logic [3:0]  wave_nxt;
  logic        bonus_given, bonus_nxt, bonus;
  logic        pause_done, last_kill, kill_ok;

  bcd_adder u_bcd_adder (
    .a   (score),
    .b   (KILL_BCD),
    .sum (sum)
  );

  assign pause_done = frame_tick && (pause_cnt == 8'(PAUSE_FRAMES - 1));
  assign kill_ok    = invader_killed && (invaders_left != 6'd0);
  assign last_kill  = invader_killed && (invaders_left == 6'd1);

`ifdef EXTRA_LIFE_EN
  assign bonus = invader_killed && !bonus_given &&
                 (score < BONUS_THRESHOLD) && (sum >= BONUS_THRESHOLD);
`else
  assign bonus = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PLAYING: begin
        if (invader_landed || (player_hit && lives <= 3'd1)) state_nxt = DONE;
        else if (last_kill)                                  state_nxt = WAVE_CLEAR;
        else if (player_hit)                                 state_nxt = HIT_PAUSE;
      end
      HIT_PAUSE, WAVE_CLEAR: if (pause_done) state_nxt = PLAYING;
      default: ;
    endcase
    if (start) state_nxt = PLAYING;
  end

  always_comb begin
    lives_nxt = lives;
    score_nxt = score;
    inv_nxt   = invaders_left;
    wave_nxt  = wave;
    pause_nxt = pause_cnt;
    bonus_nxt = bonus_given;
    lives_sum = '0;
    if (start) begin
      lives_nxt = 3'(START_LIVES);
      score_nxt = '0;
      inv_nxt   = 6'(NUM_INVADERS);
      wave_nxt  = 4'd1;
      pause_nxt = '0;
      bonus_nxt = 1'b0;
    end else begin
      case (state)
        PLAYING: begin
          // Score credit survives a landing; everything else the landing overrides.
          if (invader_killed) score_nxt = sum;
          if (invader_landed) begin
            lives_nxt = '0;
          end else begin
            if (kill_ok) inv_nxt = invaders_left - 6'd1;
            if (player_hit && lives <= 3'd1) begin
              lives_nxt = '0;
            end else begin
              lives_sum = {1'b0, lives} - {3'b0, player_hit} + {3'b0, bonus};
              lives_nxt = (lives_sum > 4'd7) ? 3'd7 : lives_sum[2:0];
              if (bonus) bonus_nxt = 1'b1;
            end
          end
        end
        HIT_PAUSE, WAVE_CLEAR: begin
          if (frame_tick) begin
            pause_nxt = pause_done ? 8'd0 : pause_cnt + 8'd1;
            if (pause_done && state == WAVE_CLEAR) begin
              inv_nxt  = 6'(NUM_INVADERS);
              wave_nxt = (wave == 4'd15) ? 4'd1 : wave + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      finished         <= 1'b0;
      playfield_active <= 1'b0;
      lives            <= '0;
      score            <= '0;
      invaders_left    <= '0;
      wave             <= '0;
      pause_cnt        <= '0;
      bonus_given      <= 1'b0;
    end else begin
      finished         <= (state_nxt == DONE);
      playfield_active <= (state_nxt == PLAYING);
      lives            <= lives_nxt;
      score            <= score_nxt;
      invaders_left    <= inv_nxt;
      wave             <= wave_nxt;
      pause_cnt        <= pause_nxt;
      bonus_given      <= bonus_nxt;
    end
  end

endmodule

// File: tb/tb_game_status_tracker.sv
// Directed scenarios plus randomized play, every cycle checked against a
// decimal-arithmetic reference model of the game rules.
module tb_game_status_tracker;

  localparam int N  = 55;
  localparam int SL = 3;
  localparam int KP = 10;
  localparam int PF = 60;
`ifdef EXTRA_LIFE_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif

  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_WAVE = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        reset, start, frame_tick, player_hit, invader_killed, invader_landed;
  logic        finished, playfield_active;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [5:0]  invaders_left;
  logic [3:0]  wave;

  int vectors = 0;
  int errors  = 0;

  int m_st = M_IDLE, m_lives = 0, m_score = 0, m_inv = 0, m_wave = 0, m_pause = 0;
  bit m_bonus = 1'b0;

  game_status_tracker #(
    .NUM_INVADERS (N),
    .START_LIVES  (SL),
    .KILL_POINTS  (KP),
    .PAUSE_FRAMES (PF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .frame_tick       (frame_tick),
    .player_hit       (player_hit),
    .invader_killed   (invader_killed),
    .invader_landed   (invader_landed),
    .finished         (finished),
    .playfield_active (playfield_active),
    .lives            (lives),
    .score            (score),
    .invaders_left    (invaders_left),
    .wave             (wave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dec2bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit st, input bit tk, input bit h,
                            input bit k, input bit l);
    int ns;
    bit bn;
    if (!r) begin
      m_st = M_IDLE; m_lives = 0; m_score = 0; m_inv = 0; m_wave = 0; m_pause = 0; m_bonus = 0;
    end else if (st) begin
      m_st = M_PLAY; m_lives = SL; m_score = 0; m_inv = N; m_wave = 1; m_pause = 0; m_bonus = 0;
    end else if (m_st == M_PLAY) begin
      ns = k ? ((m_score + KP > 9999) ? 9999 : m_score + KP) : m_score;
      bn = EXTRA && k && !m_bonus && (m_score < 1000) && (ns >= 1000);
      m_score = ns;
      if (l) begin
        m_lives = 0; m_st = M_DONE;
      end else begin
        if (k && m_inv > 0) m_inv--;
        if (h && m_lives == 1) begin
          m_lives = 0; m_st = M_DONE;
        end else begin
          m_lives = m_lives - int'(h) + int'(bn);
          if (m_lives > 7) m_lives = 7;
          if (bn) m_bonus = 1;
          if (k && m_inv == 0) m_st = M_WAVE;
          else if (h)          m_st = M_HIT;
        end
      end
    end else if ((m_st == M_HIT || m_st == M_WAVE) && tk) begin
      m_pause++;
      if (m_pause == PF) begin
        m_pause = 0;
        if (m_st == M_WAVE) begin
          m_inv  = N;
          m_wave = (m_wave == 15) ? 1 : m_wave + 1;
        end
        m_st = M_PLAY;
      end
    end
  endtask

  task automatic compare_all();
    chk("finished", 32'(finished), 32'(m_st == M_DONE));
    chk("playfield_active", 32'(playfield_active), 32'(m_st == M_PLAY));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("score", 32'(score), 32'(dec2bcd(m_score)));
    chk("invaders_left", 32'(invaders_left), 32'(m_inv));
    chk("wave", 32'(wave), 32'(m_wave));
  endtask

  task automatic apply(input bit r, input bit st, input bit tk, input bit h,
                       input bit k, input bit l);
    reset = r; start = st; frame_tick = tk; player_hit = h; invader_killed = k; invader_landed = l;
    model_step(r, st, tk, h, k, l);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 1, 0, 0, 0);
  endtask

  task automatic kills(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset overrides a coincident start.
    apply(0, 1, 0, 0, 0, 0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_pf", 32'(playfield_active), 32'd0);
    apply(1, 1, 0, 0, 0, 0);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_inv", 32'(invaders_left), 32'd55);
    chk("start_pf", 32'(playfield_active), 32'd1);

    // Full wave clear and refill.
    kills(N);
    chk("wave1_score", 32'(score), 32'h0550);
    chk("wave1_pf", 32'(playfield_active), 32'd0);
    ticks(PF);
    chk("wave2_wave", 32'(wave), 32'd2);
    chk("wave2_inv", 32'(invaders_left), 32'd55);
    chk("wave2_pf", 32'(playfield_active), 32'd1);

    // Three hits through pauses, then ignored kills in DONE.
    apply(1, 0, 0, 1, 0, 0);
    chk("hit1_lives", 32'(lives), 32'd2);
    ticks(PF - 1);
    chk("hit1_still_paused", 32'(playfield_active), 32'd0);
    ticks(1);
    apply(1, 0, 0, 1, 0, 0);
    chk("hit2_lives", 32'(lives), 32'd1);
    ticks(PF);
    apply(1, 0, 0, 1, 0, 0);
    chk("hit3_finished", 32'(finished), 32'd1);
    kills(3);
    chk("done_score", 32'(score), 32'h0550);
    apply(1, 1, 0, 0, 0, 0);
    chk("restart_finished", 32'(finished), 32'd0);

    // Last kill coincident with hit, then kill coincident with landing.
    apply(1, 0, 0, 1, 0, 0);
    ticks(PF);
    kills(N - 1);
    apply(1, 0, 0, 1, 1, 0);
    chk("kh_lives", 32'(lives), 32'd1);
    chk("kh_inv", 32'(invaders_left), 32'd0);
    ticks(PF);
    apply(1, 0, 0, 0, 1, 1);
    chk("land_score", 32'(score), 32'h0560);
    chk("land_finished", 32'(finished), 32'd1);

    // Score saturation (and extra life when enabled).
    apply(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4000 && m_score < 9999; i++) begin
      if (m_st == M_PLAY) apply(1, 0, 0, 0, 1, 0);
      else                apply(1, 0, 1, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) apply(1, 0, m_st != M_PLAY, 0, m_st == M_PLAY, 0);
    chk("sat_score", 32'(score), 32'h9999);
    chk("sat_lives", 32'(lives), EXTRA ? 32'd4 : 32'd3);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      bit r, st;
      r  = ($urandom % 500) != 0;
      st = (m_st == M_DONE || m_st == M_IDLE) ? (($urandom % 20) == 0) : (($urandom % 400) == 0);
      apply(r, st, ($urandom % 2) == 0, ($urandom % 40) == 0,
            ($urandom % 3) == 0, ($urandom % 400) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
